leb128_stream_decoder: RTL and testbench

Parametrised LEB128 decoder for the OBU header and size path. It accepts a byte stream under a valid/ready handshake and accumulates 7-bit payload groups, least significant first, until a byte with bit 7 clear arrives. It then presents the decoded value and its byte count under an output valid/ready handshake. It replaces the fixed 56-bit, stall-driven parser with configurable maximum length, overflow detection, abort and output backpressure.

---
 rtl/leb128_pkg.sv | 24 ++
 rtl/leb128_stream_decoder.sv | 107 ++++++++++
 tb/tb_leb128_stream_decoder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/leb128_pkg.sv
// ---------------------------------------------------------------------------
// leb128_pkg : shared types and constants for the LEB128 stream decoder
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package leb128_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } leb_state_t;

  localparam int LEB_PAYLOAD_W = 7;
  localparam int LEB_CONT_BIT  = 7;

  function automatic bit leb_max_bytes_ok(input int n);
    return (n >= 1) && (n <= 10);
  endfunction

endpackage

`default_nettype wire

// File: rtl/leb128_stream_decoder.sv
// ---------------------------------------------------------------------------
// leb128_stream_decoder : valid/ready LEB128 byte-stream to integer decoder
// Revision              : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module leb128_stream_decoder
  import leb128_pkg::*;
#(
  parameter int MAX_BYTES = 8,
  parameter int OUT_W     = 7 * MAX_BYTES,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  output logic [OUT_W-1:0] value,
  output logic [CNT_W-1:0] num_bytes,
  output logic             err_overflow,
  output logic             value_valid,
  input  logic             value_ready,
  output logic             busy
);

  localparam logic [1:0] c_st_idle  = IDLE;
  localparam logic [1:0] c_st_accum = ACCUM;
  localparam logic [1:0] c_st_done  = DONE;
  localparam int         c_lsb_w    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  generate
    if (!leb_max_bytes_ok(MAX_BYTES) || (OUT_W != LEB_PAYLOAD_W * MAX_BYTES)) begin : g_param_check
      $error("leb128_stream_decoder: MAX_BYTES must be 1..10 and OUT_W must equal 7*MAX_BYTES");
    end
  endgenerate

  logic [1:0]         r_state;
  logic [OUT_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               r_valid;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_last_slot;
  logic [c_lsb_w-1:0] w_lsb;

  assign w_in_ready  = !abort && (((r_state == c_st_idle) && start) || (r_state == c_st_accum));
  assign w_accept    = in_valid && w_in_ready;
  assign w_last_slot = (r_cnt == CNT_W'(MAX_BYTES - 1));
  assign w_lsb       = c_lsb_w'(r_cnt) * c_lsb_w'(LEB_PAYLOAD_W);

  // acc/cnt are always zero in IDLE (reset, abort and handshake all clear
  // them), so a start+accept cycle can OR the first payload in directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else if (abort) begin
      r_state <= c_st_idle;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_acc[w_lsb +: LEB_PAYLOAD_W] <= r_acc[w_lsb +: LEB_PAYLOAD_W] | in_byte[LEB_PAYLOAD_W-1:0];
      r_cnt <= r_cnt + CNT_W'(1);
      if (!in_byte[LEB_CONT_BIT]) begin
        r_state <= c_st_done;
        r_valid <= 1'b1;
        r_ovf   <= 1'b0;
      end else if (w_last_slot) begin
        r_state <= c_st_done;
        r_valid <= 1'b1;
        r_ovf   <= 1'b1;
      end else begin
        r_state <= c_st_accum;
      end
    end else if ((r_state == c_st_idle) && start) begin
      r_state <= c_st_accum;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if ((r_state == c_st_done) && value_ready) begin
      r_state <= c_st_idle;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end
  end

  assign in_ready     = w_in_ready;
  assign busy         = (r_state != c_st_idle);
  assign value        = r_acc;
  assign num_bytes    = r_cnt;
  assign err_overflow = r_ovf;
  assign value_valid  = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_leb128_stream_decoder.sv
// ---------------------------------------------------------------------------
// tb_leb128_stream_decoder : vector table, corner sequences and random streams
// Revision                 : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_leb128_stream_decoder;

  localparam int MB    = 8;
  localparam int OUT_W = 7 * MB;
  localparam int CNT_W = $clog2(MB + 1);

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic [79:0] bytes;
    int          len;
    logic [63:0] exp_v;
    int          exp_n;
    bit          exp_ovf;
    int          gap;
    int          rdy;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_byte;
  logic [OUT_W-1:0] value;
  logic [CNT_W-1:0] num_bytes;
  logic             err_overflow;
  logic             value_valid;
  logic             value_ready;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  leb128_stream_decoder #(.MAX_BYTES(MB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_byte     (in_byte),
    .value       (value),
    .num_bytes   (num_bytes),
    .err_overflow(err_overflow),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: sum of payload groups weighted by 128^i, stopping at the
  // first clear continuation bit or after MB bytes.
  function automatic void ref_decode(input byte_q_t q, output logic [63:0] v,
                                     output int n, output bit ovf);
    v = 0; n = 0; ovf = 0;
    foreach (q[i]) begin
      v = v + (64'(q[i][6:0]) << (7 * i));
      n = i + 1;
      if (!q[i][7]) return;
      if (n == MB) begin
        ovf = 1;
        return;
      end
    end
  endfunction

  // gap: 0 none, 1 alternate cycles, 2 random. Leaves inputs idle, aligned
  // at posedge+1, with the result handshaken.
  task automatic run_seq(input byte_q_t q, input int gap, input int rdy, input bit swf,
                         input bit poke_start, output logic [63:0] v, output int n,
                         output bit ovf, output int lat, output int used);
    int  idx = 0;
    int  cyc = 0;
    bit  acc;
    while (!value_valid && cyc < 100) begin
      if (cyc == 0) begin
        start    = 1'b1;
        in_valid = swf;
      end else begin
        start = 1'b0;
        case (gap)
          1:       in_valid = (cyc % 2 == 0);
          2:       in_valid = ($urandom_range(0, 99) >= 30);
          default: in_valid = 1'b1;
        endcase
      end
      if (idx >= q.size()) in_valid = 1'b0;
      in_byte = in_valid ? q[idx] : 8'($urandom);
      #1;
      if (cyc == 0) chk("start_in_ready", in_ready, 1);
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
      cyc++;
    end
    if (!value_valid) chk("result_timeout", 0, 1);
    start = 1'b0;
    lat = cyc;
    v   = 64'(value);
    n   = int'(num_bytes);
    ovf = err_overflow;
    for (int k = 0; k < rdy; k++) begin
      in_valid    = (idx < q.size());
      in_byte     = in_valid ? q[idx] : 8'h00;
      start       = poke_start;
      value_ready = 1'b0;
      #1;
      chk("hold_in_ready", in_ready, 0);
      tick();
      chk("hold_valid", value_valid, 1);
      chk("hold_value", 64'(value), v);
      chk("hold_busy", busy, 1);
    end
    value_ready = 1'b1;
    start       = poke_start;
    tick();
    value_ready = 1'b0;
    start       = 1'b0;
    in_valid    = 1'b0;
    chk("post_valid", value_valid, 0);
    chk("post_busy", busy, 0);
    used = idx;
  endtask

  vec_t        tbl[9];
  byte_q_t     q;
  logic [63:0] v, ev;
  int          n, en, lat, used;
  bit          ovf, eovf;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    in_byte = 8'h00; value_ready = 1'b0;

    tbl[0] = '{80'h05,                   1, 64'd5,                1, 1'b0, 0, 0};
    tbl[1] = '{80'h26_8E_E5,             3, 64'd624485,           3, 1'b0, 1, 0};
    tbl[2] = '{80'hFF_FFFF_FFFF_FFFF_FFFF, 9, 64'h00FF_FFFF_FFFF_FFFF, 8, 1'b1, 0, 1};
    tbl[3] = '{80'h7F,                   1, 64'd127,              1, 1'b0, 0, 5};
    tbl[4] = '{80'h00_80_80_80,          4, 64'd0,                4, 1'b0, 0, 0};
    tbl[5] = '{80'h00,                   1, 64'd0,                1, 1'b0, 0, 2};
    tbl[6] = '{80'h01_80,                2, 64'd128,              2, 1'b0, 2, 0};
    tbl[7] = '{80'h7F_FF_FF,             3, 64'h1F_FFFF,          3, 1'b0, 0, 0};
    tbl[8] = '{80'h01_8080_8080_8080_80, 8, 64'h2_0000_0000_0000, 8, 1'b0, 0, 0};

    tick(); tick();
    chk("rst_value", 64'(value), 0);
    chk("rst_num_bytes", 64'(num_bytes), 0);
    chk("rst_err", err_overflow, 0);
    chk("rst_valid", value_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 9; t++) begin
      q = {};
      for (int i = 0; i < tbl[t].len; i++) q.push_back(tbl[t].bytes[8*i +: 8]);
      run_seq(q, tbl[t].gap, tbl[t].rdy, 1'b1, tbl[t].rdy > 0, v, n, ovf, lat, used);
      chk($sformatf("tbl%0d_value", t), v, tbl[t].exp_v);
      chk($sformatf("tbl%0d_num", t), 64'(n), 64'(tbl[t].exp_n));
      chk($sformatf("tbl%0d_ovf", t), ovf, tbl[t].exp_ovf);
      chk($sformatf("tbl%0d_used", t), 64'(used), 64'(tbl[t].exp_n));
      if (tbl[t].gap == 0) chk($sformatf("tbl%0d_latency", t), 64'(lat), 64'(tbl[t].exp_n));
    end

    // abort mid-value, then a fresh value must carry no stale bits
    start = 1'b1; in_valid = 1'b1; in_byte = 8'h80;
    tick();
    start = 1'b0; in_byte = 8'h80;
    tick();
    abort = 1'b1; in_byte = 8'h05;
    #1;
    chk("abort_in_ready", in_ready, 0);
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", value_valid, 0);
    chk("abort_num", 64'(num_bytes), 0);
    q = {8'h01};
    run_seq(q, 0, 0, 1'b1, 1'b0, v, n, ovf, lat, used);
    chk("after_abort_value", v, 1);
    chk("after_abort_num", 64'(n), 1);

    // abort while holding a result drops it
    start = 1'b1; in_valid = 1'b1; in_byte = 8'h03;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("done_valid", value_valid, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("done_abort_valid", value_valid, 0);
    chk("done_abort_busy", busy, 0);

    // asynchronous reset mid-value
    start = 1'b1; in_valid = 1'b1; in_byte = 8'h81;
    tick();
    start = 1'b0; in_byte = 8'h83;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_value", 64'(value), 0);
    chk("arst_num", 64'(num_bytes), 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_valid", value_valid, 0);
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    q = {8'h02};
    run_seq(q, 0, 0, 1'b1, 1'b0, v, n, ovf, lat, used);
    chk("after_rst_value", v, 2);
    chk("after_rst_num", 64'(n), 1);

    // random streams against the reference
    for (int r = 0; r < 40; r++) begin
      int len;
      bit force_ovf;
      q = {};
      force_ovf = ($urandom_range(0, 7) == 0);
      len = force_ovf ? MB + $urandom_range(0, 1) : $urandom_range(1, MB);
      for (int i = 0; i < len; i++)
        q.push_back({(force_ovf || i < len - 1), 7'($urandom)});
      ref_decode(q, ev, en, eovf);
      run_seq(q, 2, $urandom_range(0, 3), 1'($urandom), 1'($urandom), v, n, ovf, lat, used);
      chk($sformatf("rnd%0d_value", r), v, ev);
      chk($sformatf("rnd%0d_num", r), 64'(n), 64'(en));
      chk($sformatf("rnd%0d_ovf", r), ovf, eovf);
      chk($sformatf("rnd%0d_used", r), 64'(used), 64'(en));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
